pc_sequencer: RTL and testbench

Parametrised program-counter unit for the core, with a split low/high PC. It holds the PC and applies increment and bus loads, and executes relative branches with a page-cross fix-up cycle. It also gates everything on the ready line. It sits between the decoder/random-logic outputs (which issue commands) and the ADL/ADH/DB bus drivers (which consume `pc_lo`/`pc_hi`).

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/pc_half.sv | 50 +++++
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared state encoding and defaults for the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [0:0] {
        PCS_IDLE = 1'b0,
        PCS_FIX  = 1'b1
    } pcs_state_t;

    localparam int          c_LO_W_DEFAULT         = 8;
    localparam int          c_HI_W_DEFAULT         = 8;
    localparam logic [15:0] c_RESET_VECTOR_DEFAULT = 16'hFFFC;

endpackage

`default_nettype wire

// File: rtl/pc_half.sv
// ============================================================================
// Module      : pc_half
// Description : One half of the program counter: load, add-with-carry, +/-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_half #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         add_en,
    input  logic [W-1:0] add_b,
    input  logic         add_cin,
    input  logic         step_en,
    input  logic         step_dn,
    output logic [W-1:0] q,
    output logic         cout
);

    logic [W-1:0] r_q;
    logic [W:0]   w_sum;
    logic [W-1:0] w_step;

    // Carry-out is always live so the other half can chain off it combinationally.
    assign w_sum  = {1'b0, r_q} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign w_step = step_dn ? (r_q - W'(1)) : (r_q + W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (ld) begin
            r_q <= ld_val;
        end else if (add_en) begin
            r_q <= w_sum[W-1:0];
        end else if (step_en) begin
            r_q <= w_step;
        end
    end

    assign q    = r_q;
    assign cout = w_sum[W];

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Split PCL/PCH program counter with relative-branch fix-up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                     LO_W         = c_LO_W_DEFAULT,
    parameter int                     HI_W         = c_HI_W_DEFAULT,
    parameter logic [LO_W+HI_W-1:0]   RESET_VECTOR = (LO_W+HI_W)'(c_RESET_VECTOR_DEFAULT)
) (
    input  logic            PHI0,
    input  logic            RES,
    input  logic            ready,
    input  logic            inc,
    input  logic            ld_lo,
    input  logic            ld_hi,
    input  logic [LO_W-1:0] adl_in,
    input  logic [HI_W-1:0] adh_in,
    input  logic            br_start,
    input  logic [LO_W-1:0] br_off,
    output logic [LO_W-1:0] pc_lo,
    output logic [HI_W-1:0] pc_hi,
    output logic            busy,
    output logic            page_cross
);

    pcs_state_t r_state;
    pcs_state_t w_state_nxt;
    logic       r_dir;
    logic       w_dir_nxt;
    logic       r_page_cross;

    logic       w_idle_go;
    logic       w_fix_go;
    logic       w_br;
    logic       w_ld_lo;
    logic       w_ld_hi;
    logic       w_inc;
    logic       w_br_sign;
    logic       w_cross;
    logic       w_lo_cout;
    logic       w_hi_cout_unused;

    // Command decode: branch beats loads, loads beat increment.
    assign w_idle_go = ready && (r_state == PCS_IDLE);
    assign w_fix_go  = ready && (r_state == PCS_FIX);
    assign w_br      = w_idle_go && br_start;
    assign w_ld_lo   = w_idle_go && !br_start && ld_lo;
    assign w_ld_hi   = w_idle_go && !br_start && ld_hi;
    assign w_inc     = w_idle_go && !br_start && !ld_lo && !ld_hi && inc;

    assign w_br_sign = br_off[LO_W-1];
    assign w_cross   = w_lo_cout ^ w_br_sign;

    pc_half #(
        .W       (LO_W),
        .RST_VAL (RESET_VECTOR[LO_W-1:0])
    ) u_pcl (
        .clk     (PHI0),
        .rst     (RES),
        .ld      (w_ld_lo),
        .ld_val  (adl_in),
        .add_en  (w_br || w_inc),
        .add_b   (w_br ? br_off : '0),
        .add_cin (w_inc),
        .step_en (1'b0),
        .step_dn (1'b0),
        .q       (pc_lo),
        .cout    (w_lo_cout)
    );

    // PCH takes the PCL carry on increment and the +/-1 step on fix-up.
    pc_half #(
        .W       (HI_W),
        .RST_VAL (RESET_VECTOR[LO_W+HI_W-1:LO_W])
    ) u_pch (
        .clk     (PHI0),
        .rst     (RES),
        .ld      (w_ld_hi),
        .ld_val  (adh_in),
        .add_en  (w_inc),
        .add_b   ('0),
        .add_cin (w_lo_cout),
        .step_en (w_fix_go),
        .step_dn (r_dir),
        .q       (pc_hi),
        .cout    (w_hi_cout_unused)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        case (r_state)
            PCS_IDLE: begin
                if (w_br && w_cross) begin
                    w_state_nxt = PCS_FIX;
                    w_dir_nxt   = w_br_sign;
                end
            end
            PCS_FIX: begin
                if (ready) begin
                    w_state_nxt = PCS_IDLE;
                end
            end
            default: w_state_nxt = PCS_IDLE;
        endcase
    end

    always_ff @(posedge PHI0 or posedge RES) begin
        if (RES) begin
            r_state      <= PCS_IDLE;
            r_dir        <= 1'b0;
            r_page_cross <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dir        <= w_dir_nxt;
            r_page_cross <= w_fix_go;
        end
    end

    assign busy       = (r_state == PCS_FIX);
    assign page_cross = r_page_cross;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed, table-driven bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic       PHI0 = 1'b0;
    logic       RES  = 1'b1;
    logic       ready = 1'b1;
    logic       inc = 1'b0, ld_lo = 1'b0, ld_hi = 1'b0, br_start = 1'b0;
    logic [7:0] adl_in = '0, adh_in = '0, br_off = '0;
    logic [7:0] pc_lo, pc_hi;
    logic       busy, page_cross;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .PHI0       (PHI0),
        .RES        (RES),
        .ready      (ready),
        .inc        (inc),
        .ld_lo      (ld_lo),
        .ld_hi      (ld_hi),
        .adl_in     (adl_in),
        .adh_in     (adh_in),
        .br_start   (br_start),
        .br_off     (br_off),
        .pc_lo      (pc_lo),
        .pc_hi      (pc_hi),
        .busy       (busy),
        .page_cross (page_cross)
    );

    always #5 PHI0 = ~PHI0;

    typedef struct {
        logic        rdy;
        logic        inc;
        logic        ldl;
        logic        ldh;
        logic [7:0]  adl;
        logic [7:0]  adh;
        logic        br;
        logic [7:0]  off;
        logic [15:0] pc;
        logic        busy;
        logic        pcx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rdy, logic i, logic ll, logic lh,
                                logic [7:0] al, logic [7:0] ah, logic b,
                                logic [7:0] o, logic [15:0] p, logic bz, logic px);
        vec_t v;
        v.rdy = rdy; v.inc = i; v.ldl = ll; v.ldh = lh; v.adl = al; v.adh = ah;
        v.br = b; v.off = o; v.pc = p; v.busy = bz; v.pcx = px;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] pc,
                             input logic bz, input logic px);
        check({name, ".pc"}, {pc_hi, pc_lo}, pc);
        check({name, ".busy"}, {15'd0, busy}, {15'd0, bz});
        check({name, ".page_cross"}, {15'd0, page_cross}, {15'd0, px});
    endtask

    task automatic drive(input vec_t v);
        ready = v.rdy; inc = v.inc; ld_lo = v.ldl; ld_hi = v.ldh;
        adl_in = v.adl; adh_in = v.adh; br_start = v.br; br_off = v.off;
    endtask

    initial begin
        //        rdy inc ldl ldh adl    adh    br  off    pc        busy pcx
        vecs.push_back(mk(1, 0, 1, 1, 8'hFF, 8'h12, 0, 8'h00, 16'h12FF, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h1300, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 8'hFF, 8'hFF, 0, 8'h00, 16'hFFFF, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 8'h00, 8'h56, 0, 8'h00, 16'h5600, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 8'h34, 8'h99, 0, 8'h00, 16'h5634, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8'h77, 8'hAB, 0, 8'h00, 16'hAB34, 0, 0));
        // branches without page cross
        vecs.push_back(mk(1, 0, 1, 1, 8'h10, 8'h20, 0, 8'h00, 16'h2010, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h05, 16'h2015, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 8'h10, 8'h20, 0, 8'h00, 16'h2010, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'hF0, 16'h2000, 0, 0));
        // forward page cross
        vecs.push_back(mk(1, 0, 1, 1, 8'hF0, 8'h20, 0, 8'h00, 16'h20F0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h20, 16'h2010, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h2110, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h2110, 0, 0));
        // backward page cross
        vecs.push_back(mk(1, 0, 1, 1, 8'h05, 8'h20, 0, 8'h00, 16'h2005, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'hF0, 16'h20F5, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h1FF5, 0, 1));
        // ready stall in FIX with inc held, then immediate re-branch
        vecs.push_back(mk(1, 0, 1, 1, 8'hF0, 8'h20, 0, 8'h00, 16'h20F0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h20, 16'h2010, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h2010, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h2010, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h2010, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h2110, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h05, 16'h2115, 0, 0));
        // branch with carry but negative offset: no cross
        vecs.push_back(mk(1, 0, 1, 1, 8'h80, 8'h20, 0, 8'h00, 16'h2080, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h90, 16'h2010, 0, 0));
        // loads dropped while busy
        vecs.push_back(mk(1, 0, 1, 1, 8'hF0, 8'h30, 0, 8'h00, 16'h30F0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h20, 16'h3010, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 8'h55, 8'h66, 1, 8'h7F, 16'h3110, 0, 1));
        // ready low in IDLE freezes everything
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h3110, 0, 0));
        // backward fix-up wrapping PCH 00 -> FF
        vecs.push_back(mk(1, 0, 1, 1, 8'h05, 8'h00, 0, 8'h00, 16'h0005, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'hF0, 16'h00F5, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'hFFF5, 0, 1));

        // Reset state
        repeat (2) @(negedge PHI0);
        check_all("reset_held", 16'hFFFC, 1'b0, 1'b0);
        RES = 1'b0;
        @(posedge PHI0); #1;
        check_all("reset_release", 16'hFFFC, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge PHI0);
            drive(vecs[i]);
            @(posedge PHI0); #1;
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].busy, vecs[i].pcx);
        end

        // Reset asserted mid-FIX aborts the fix-up immediately
        @(negedge PHI0);
        drive(mk(1, 0, 1, 1, 8'hF0, 8'h40, 0, 8'h00, 16'h0, 0, 0));
        @(negedge PHI0);
        drive(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h20, 16'h0, 0, 0));
        @(posedge PHI0); #1;
        check_all("pre_reset_fix", 16'h4010, 1'b1, 1'b0);
        drive(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h0, 0, 0));
        #2 RES = 1'b1;
        #1;
        check_all("reset_mid_fix", 16'hFFFC, 1'b0, 1'b0);
        @(posedge PHI0); #1;
        check_all("reset_mid_fix_hold", 16'hFFFC, 1'b0, 1'b0);
        @(negedge PHI0);
        RES = 1'b0;
        @(posedge PHI0); #1;
        check_all("after_reset_fix", 16'hFFFC, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
